// File: rtl/jtag_axi_dr_if.sv
// Bundle of TAP-strobe, serial-data and AXI-stage command/readback signals for jtag_axi_dr.
interface jtag_axi_dr_if #(
    parameter int DR_WIDTH = 96,
    parameter int RD_WIDTH = 64
);
    logic                sel_i;
    logic                capture_dr_i;
    logic                shift_dr_i;
    logic                update_dr_i;
    logic                tdi_i;
    logic                tdo_o;
    logic [RD_WIDTH-1:0] rdata_i;
    logic                done_i;
    logic [DR_WIDTH-1:0] axireg_o;
    logic                update_o;
    logic                busy_o;

    modport slave (
        input  sel_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i, rdata_i, done_i,
        output tdo_o, axireg_o, update_o, busy_o
    );

    modport master (
        output sel_i, capture_dr_i, shift_dr_i, update_dr_i, tdi_i, rdata_i, done_i,
        input  tdo_o, axireg_o, update_o, busy_o
    );
endinterface

// File: rtl/jtag_axi_dr.sv
// JTAG data register feeding an AXI command stage: scan shift register, shadow command
// register, pending/overrun tracking with clear-on-capture status readback.
module jtag_axi_dr #(
    parameter int DR_WIDTH = 96,
    parameter int RD_WIDTH = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    jtag_axi_dr_if.slave  bus
);
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [DR_WIDTH-1:0] sh_q, sh_d;
    logic                pend_q, pend_d;
    logic                ovr_q, ovr_d;
    logic                upd_q, upd_d;

    // Capture word: readback data, then status {ovr, pend, valid}, zero-filled above.
    function automatic logic [DR_WIDTH-1:0] capture_word(
        input logic [RD_WIDTH-1:0] rd,
        input logic                ovr,
        input logic                pend
    );
        logic [DR_WIDTH-1:0] w;
        w                         = '0;
        w[RD_WIDTH-1:0]           = rd;
        w[RD_WIDTH+2:RD_WIDTH]    = {ovr, pend, 1'b1};
        return w;
    endfunction

    // Next-state: done clears pending first so a same-cycle update is accepted.
    always_comb begin
        sr_d   = sr_q;
        sh_d   = sh_q;
        ovr_d  = ovr_q;
        upd_d  = 1'b0;
        if (bus.done_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (bus.sel_i) begin
            if (bus.capture_dr_i) begin
                sr_d  = capture_word(bus.rdata_i, ovr_q, pend_q);
                ovr_d = 1'b0;
            end else if (bus.shift_dr_i) begin
                sr_d = {bus.tdi_i, sr_q[DR_WIDTH-1:1]};
            end else if (bus.update_dr_i) begin
                if (!pend_q || bus.done_i) begin
                    sh_d   = sr_q;
                    pend_d = 1'b1;
                    upd_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                sr_d = sr_q;
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q   <= '0;
            sh_q   <= '0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            sh_q   <= sh_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            upd_q  <= upd_d;
        end
    end

    assign bus.tdo_o    = sr_q[0];
    assign bus.axireg_o = sh_q;
    assign bus.update_o = upd_q;
    assign bus.busy_o   = pend_q;
endmodule

// File: doc/jtag_axi_dr.md
JTAG_AXI_DR -- requirements
Module: jtag_axi_dr

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 96, giving the scan data register length in bits.
REQ-002 SHALL have parameter RD_WIDTH, default 64, giving the width of the readback word from the AXI stage.
REQ-003 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 sel_i  input  1  this DR is selected by the TAP instruction register.
REQ-006 capture_dr_i  input  1  one-cycle strobe for the Capture-DR state.
REQ-007 shift_dr_i  input  1  one-cycle strobe per bit for the Shift-DR state.
REQ-008 update_dr_i  input  1  one-cycle strobe for the Update-DR state.
REQ-009 tdi_i  input  1  serial data in.
REQ-010 tdo_o  output  1  serial data out, equal to shift register bit 0.
REQ-011 rdata_i  input  RD_WIDTH  readback word from the AXI stage.
REQ-012 done_i  input  1  one-cycle pulse: the AXI stage returned to idle after a transaction.
REQ-013 axireg_o  output  DR_WIDTH  shadow (update) register that drives the AXI stage command word.
REQ-014 update_o  output  1  one-cycle pulse: a new command is valid on axireg_o.
REQ-015 busy_o  output  1  a command was issued and done_i has not yet been seen.

Function
REQ-016 SHALL hold a DR_WIDTH shift register SR, a DR_WIDTH shadow register SH, and flags PEND and OVR.
REQ-017 Strobes SHALL act only when sel_i=1; with sel_i=0, SR, SH, OVR and update_o SHALL be unaffected, and update_o SHALL be 0.
REQ-018 Capture (capture_dr_i=1) SHALL load SR[RD_WIDTH-1:0]=rdata_i and SR[RD_WIDTH+2:RD_WIDTH]={OVR,PEND,1'b1}, with all remaining SR bits set to 0.
REQ-019 Capture SHALL sample the pre-edge values of OVR and PEND and SHALL clear OVR on the same edge (clear-on-read).
REQ-020 Shift (shift_dr_i=1) SHALL perform SR <= {tdi_i, SR[DR_WIDTH-1:1]}, with tdo_o=SR[0] combinational from the register.
REQ-021 Update with PEND=0 SHALL load SH<=SR, set PEND, and assert update_o for exactly the next cycle, with axireg_o already holding the new value in that cycle.
REQ-022 Update with PEND=1 SHALL leave SH unchanged, SHALL NOT pulse update_o, and SHALL set OVR.
REQ-023 done_i=1 SHALL clear PEND regardless of sel_i.
REQ-024 If done_i and a qualified update occur in the same cycle, the update SHALL be accepted as if PEND=0; PEND SHALL end set and OVR SHALL be unchanged.
REQ-025 If more than one strobe is asserted in the same cycle, the priority SHALL be capture > shift > update, and only the highest-priority strobe SHALL act.
REQ-026 busy_o SHALL equal PEND.
REQ-027 axireg_o SHALL change only on an accepted update and SHALL hold its value otherwise.
REQ-028 No bit length check SHALL be made: a shift count other than DR_WIDTH simply leaves the resulting partial SR contents.

Reset
REQ-029 While rst_ni=0 at a clock edge, SR, SH, PEND and OVR SHALL be set to 0, update_o SHALL be 0, and hence axireg_o=0, busy_o=0, tdo_o=0.
REQ-030 Reset asserted mid-shift or while busy SHALL discard all state with no update_o pulse; the first strobe after release SHALL behave as from power-up.
REQ-031 Strobes SHALL be ignored in any cycle in which rst_ni=0.

Verification
REQ-032 Reset, sel_i=1, shift 96 bits forming 0xDEADBEEF_01234567_80000003 (LSB first), then update -> update_o high exactly one cycle later; axireg_o=0xDEADBEEF_01234567_80000003; busy_o=1.
REQ-033 From the REQ-032 state, a second shift+update before done_i -> no update_o pulse, axireg_o unchanged; then capture -> SR[66:64]=3'b111; a following capture -> SR[66:64]=3'b011.
REQ-034 rdata_i=0x0011223344556677, done_i pulse, then capture and 96 shifts -> tdo_o emits 0x0011223344556677 LSB first, then bits 1,0,0 (valid, PEND=0, OVR=0), then 29 zeros.
REQ-035 done_i and update_dr_i in the same cycle with PEND=1 -> update_o pulses, busy_o stays 1, OVR stays 0.
REQ-036 sel_i=0 with all strobes toggling -> SR, SH, OVR unchanged and update_o=0; capture and shift asserted together -> capture result only.
REQ-037 rst_ni low for one cycle after 40 shifts -> SR=0, tdo_o=0, busy_o=0, and no update_o pulse.
